// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station.
// Holds the tag encoding, default operand/opcode widths, the entry record
// layout and the helper that maps an entry index to the tag it owns.
package rs_pkg;

  localparam int TAG_W = 2;
  localparam logic [TAG_W-1:0] TAG_NONE = 2'b11;  // "value valid" label
  localparam int DW  = 12;
  localparam int OPW = 3;

  // Architectural content of one entry at the default widths.
  typedef struct packed {
    logic             busy;
    logic [OPW-1:0]   op;
    logic [DW-1:0]    vj;
    logic [TAG_W-1:0] qj;
    logic [DW-1:0]    vk;
    logic [TAG_W-1:0] qk;
  } rs_entry_t;

  // Tag owned by entry idx when entry 0 owns tag base.
  function automatic logic [TAG_W-1:0] entry_tag(input int unsigned base,
                                                 input int unsigned idx);
    logic [31:0] sum;
    sum = base + idx;
    return sum[TAG_W-1:0];
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry.
// Loads opcode/operands on allocation (with same-cycle CDB bypass), snoops
// the CDB while waiting, and frees itself when the dispatch handshake picks it.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   alloc                         issue accepted into this entry this cycle
//   drain                         dispatch handshake selects this entry
//   issue_op/vj/qj/vk/qk          issue payload
//   cdb_valid/cdb_tag/cdb_data    common data bus
//   busy, ready                   entry state flags
//   op, vj, vk                    stored opcode and operand values
module rs_entry
  import rs_pkg::*;
#(
  parameter int EDW  = 12,
  parameter int EOPW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc,
  input  logic             drain,
  input  logic [EOPW-1:0]  issue_op,
  input  logic [EDW-1:0]   issue_vj,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [EDW-1:0]   issue_vk,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [EDW-1:0]   cdb_data,
  output logic             busy,
  output logic             ready,
  output logic [EOPW-1:0]  op,
  output logic [EDW-1:0]   vj,
  output logic [EDW-1:0]   vk
);

  logic [TAG_W-1:0] qj;
  logic [TAG_W-1:0] qk;

  logic             nxt_busy;
  logic [EOPW-1:0]  nxt_op;
  logic [EDW-1:0]   nxt_vj;
  logic [EDW-1:0]   nxt_vk;
  logic [TAG_W-1:0] nxt_qj;
  logic [TAG_W-1:0] nxt_qk;

  // A broadcast carrying the "valid" label never names a producer.
  logic cdb_live;
  logic byp_j;
  logic byp_k;
  logic snoop_j;
  logic snoop_k;

  assign cdb_live = cdb_valid && (cdb_tag != TAG_NONE);
  assign byp_j    = cdb_live && (issue_qj == cdb_tag);
  assign byp_k    = cdb_live && (issue_qk == cdb_tag);
  assign snoop_j  = cdb_live && (qj == cdb_tag);
  assign snoop_k  = cdb_live && (qk == cdb_tag);

  assign ready = busy && (qj == TAG_NONE) && (qk == TAG_NONE);

  // Next-state selection: allocate, free on dispatch, or snoop while waiting.
  // alloc and drain never coincide: alloc needs a free entry, drain a busy one.
  always_comb begin
    nxt_busy = busy;
    nxt_op   = op;
    nxt_vj   = vj;
    nxt_vk   = vk;
    nxt_qj   = qj;
    nxt_qk   = qk;
    if (alloc) begin
      nxt_busy = 1'b1;
      nxt_op   = issue_op;
      nxt_vj   = byp_j ? cdb_data : issue_vj;
      nxt_qj   = byp_j ? TAG_NONE : issue_qj;
      nxt_vk   = byp_k ? cdb_data : issue_vk;
      nxt_qk   = byp_k ? TAG_NONE : issue_qk;
    end else if (drain) begin
      // Freed entry: a CDB hit on this edge is irrelevant.
      nxt_busy = 1'b0;
    end else if (busy) begin
      nxt_vj = snoop_j ? cdb_data : vj;
      nxt_qj = snoop_j ? TAG_NONE : qj;
      nxt_vk = snoop_k ? cdb_data : vk;
      nxt_qk = snoop_k ? TAG_NONE : qk;
    end else begin
      nxt_busy = 1'b0;
    end
  end

  // Entry state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      op   <= {EOPW{1'b0}};
      vj   <= {EDW{1'b0}};
      vk   <= {EDW{1'b0}};
      qj   <= TAG_NONE;
      qk   <= TAG_NONE;
    end else begin
      busy <= nxt_busy;
      op   <= nxt_op;
      vj   <= nxt_vj;
      vk   <= nxt_vk;
      qj   <= nxt_qj;
      qk   <= nxt_qk;
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station between issue and a functional unit.
// Allocates the lowest free entry on issue, lets entries wake up from the
// CDB, and offers the lowest-index ready entry to the FU.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   issue_valid/ready/op/vj/qj/vk/qk    issue handshake and payload
//   issue_tag                           tag that an accepted issue receives (11 when full)
//   cdb_valid/cdb_tag/cdb_data          common data bus snoop
//   disp_valid/ready/op/a/b/tag         dispatch handshake and payload
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int TAG_BASE = 0,
  parameter int DW       = rs_pkg::DW,
  parameter int OPW      = rs_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [OPW-1:0]   issue_op,
  input  logic [DW-1:0]    issue_vj,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [DW-1:0]    issue_vk,
  input  logic [TAG_W-1:0] issue_qk,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [DW-1:0]    cdb_data,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [OPW-1:0]   disp_op,
  output logic [DW-1:0]    disp_a,
  output logic [DW-1:0]    disp_b,
  output logic [TAG_W-1:0] disp_tag
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] free_sel;   // one-hot lowest free entry
  logic [DEPTH-1:0] disp_sel;   // one-hot lowest ready entry
  logic [DEPTH-1:0] alloc;
  logic [DEPTH-1:0] drain;
  logic [OPW-1:0]   e_op [DEPTH];
  logic [DW-1:0]    e_vj [DEPTH];
  logic [DW-1:0]    e_vk [DEPTH];

  logic free_seen;
  logic ready_seen;
  logic accept;
  logic handshake;

  // Availability comes from registered busy only, so an entry freed by
  // dispatch on this edge is not handed out again on the same edge.
  assign issue_ready = ~&busy;
  assign disp_valid  = |ready;
  assign accept      = issue_valid && issue_ready;
  assign handshake   = disp_valid && disp_ready;
  assign alloc       = accept ? free_sel : {DEPTH{1'b0}};
  assign drain       = handshake ? disp_sel : {DEPTH{1'b0}};

  // Priority encoders: lowest-index free entry and lowest-index ready entry.
  always_comb begin
    free_sel   = {DEPTH{1'b0}};
    disp_sel   = {DEPTH{1'b0}};
    free_seen  = 1'b0;
    ready_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      free_sel[i] = !busy[i] && !free_seen;
      free_seen   = free_seen || !busy[i];
      disp_sel[i] = ready[i] && !ready_seen;
      ready_seen  = ready_seen || ready[i];
    end
  end

  // Tag of the allocation candidate, or TAG_NONE when every entry is busy.
  always_comb begin
    issue_tag = TAG_NONE;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      issue_tag = free_sel[i] ? entry_tag(TAG_BASE, i) : issue_tag;
    end
  end

  // Dispatch mux: AND-OR over the one-hot select; all zero when idle.
  always_comb begin
    disp_op  = {OPW{1'b0}};
    disp_a   = {DW{1'b0}};
    disp_b   = {DW{1'b0}};
    disp_tag = TAG_NONE;
    for (int i = 0; i < DEPTH; i++) begin
      disp_op  = disp_op | ({OPW{disp_sel[i]}} & e_op[i]);
      disp_a   = disp_a  | ({DW{disp_sel[i]}} & e_vj[i]);
      disp_b   = disp_b  | ({DW{disp_sel[i]}} & e_vk[i]);
      disp_tag = disp_sel[i] ? entry_tag(TAG_BASE, i) : disp_tag;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rs_entry #(
      .EDW  (DW),
      .EOPW (OPW)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc     (alloc[g]),
      .drain     (drain[g]),
      .issue_op  (issue_op),
      .issue_vj  (issue_vj),
      .issue_qj  (issue_qj),
      .issue_vk  (issue_vk),
      .issue_qk  (issue_qk),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .busy      (busy[g]),
      .ready     (ready[g]),
      .op        (e_op[g]),
      .vj        (e_vj[g]),
      .vk        (e_vk[g])
    );
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (DEPTH=2, TAG_BASE=0).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic [11:0] issue_vj;
  logic [1:0]  issue_qj;
  logic [11:0] issue_vk;
  logic [1:0]  issue_qk;
  logic [1:0]  issue_tag;
  logic        cdb_valid;
  logic [1:0]  cdb_tag;
  logic [11:0] cdb_data;
  logic        disp_valid;
  logic        disp_ready;
  logic [2:0]  disp_op;
  logic [11:0] disp_a;
  logic [11:0] disp_b;
  logic [1:0]  disp_tag;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_qj    (issue_qj),
    .issue_vk    (issue_vk),
    .issue_qk    (issue_qk),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_op     (disp_op),
    .disp_a      (disp_a),
    .disp_b      (disp_b),
    .disp_tag    (disp_tag)
  );

  // Holds an issue request across exactly one rising edge (negedge to negedge).
  task automatic do_issue(input logic [2:0] op, input logic [11:0] vj, input logic [1:0] qj,
                          input logic [11:0] vk, input logic [1:0] qk);
    issue_op    = op;
    issue_vj    = vj;
    issue_qj    = qj;
    issue_vk    = vk;
    issue_qk    = qk;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_op = 3'd0; issue_vj = 12'h000; issue_qj = 2'b11;
    issue_vk = 12'h000; issue_qk = 2'b11;
    cdb_valid = 1'b0; cdb_tag = 2'b11; cdb_data = 12'h000; disp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({issue_ready, issue_tag, disp_valid} !== {1'b1, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: ready/tag/dv got %b want 1_00_0", {issue_ready, issue_tag, disp_valid});
    end
    vectors++;
    if ({disp_op, disp_a, disp_b} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_disp_zero: got %h want 0", {disp_op, disp_a, disp_b});
    end
    do_issue(3'd1, 12'h111, 2'b10, 12'h222, 2'b11);
    do_issue(3'd2, 12'h333, 2'b11, 12'h444, 2'b10);
    vectors++;
    if ({issue_ready, issue_tag, disp_valid} !== {1'b0, 2'b11, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_prefill: ready/tag/dv got %b want 0_11_0", {issue_ready, issue_tag, disp_valid});
    end
    // Reset asserted between edges must take effect immediately.
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({issue_ready, issue_tag, disp_valid} !== {1'b1, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async: ready/tag/dv got %b want 1_00_0", {issue_ready, issue_tag, disp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({issue_ready, disp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_after: ready/dv got %b want 10", {issue_ready, disp_valid});
    end
  endtask

  task automatic test_ready_issue;
    do_issue(3'd1, 12'h00A, 2'b11, 12'h005, 2'b11);
    vectors++;
    if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 3'd1, 12'h00A, 12'h005, 2'd0}) begin
      miscompares++;
      $display("FAIL ready_issue: got %h want %h", {disp_valid, disp_op, disp_a, disp_b, disp_tag},
               {1'b1, 3'd1, 12'h00A, 12'h005, 2'd0});
    end
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
    vectors++;
    if ({disp_valid, issue_ready, issue_tag} !== {1'b0, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL ready_pop: dv/ready/tag got %b want 0_1_00", {disp_valid, issue_ready, issue_tag});
    end
  endtask

  task automatic test_wakeup;
    do_issue(3'd2, 12'h111, 2'b10, 12'h007, 2'b11);
    vectors++;
    if (disp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wakeup_wait: disp_valid got %b want 0", disp_valid);
    end
    cdb_valid = 1'b1; cdb_tag = 2'b10; cdb_data = 12'h123;
    @(negedge clk);
    cdb_valid = 1'b0;
    vectors++;
    if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 3'd2, 12'h123, 12'h007, 2'd0}) begin
      miscompares++;
      $display("FAIL wakeup: got %h want %h", {disp_valid, disp_op, disp_a, disp_b, disp_tag},
               {1'b1, 3'd2, 12'h123, 12'h007, 2'd0});
    end
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
  endtask

  task automatic test_bypass;
    cdb_valid = 1'b1; cdb_tag = 2'b10; cdb_data = 12'h0FF;
    do_issue(3'd3, 12'h050, 2'b11, 12'h999, 2'b10);
    cdb_valid = 1'b0;
    vectors++;
    if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 3'd3, 12'h050, 12'h0FF, 2'd0}) begin
      miscompares++;
      $display("FAIL bypass: got %h want %h", {disp_valid, disp_op, disp_a, disp_b, disp_tag},
               {1'b1, 3'd3, 12'h050, 12'h0FF, 2'd0});
    end
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
  endtask

  task automatic test_full;
    do_issue(3'd4, 12'h000, 2'b10, 12'h00B, 2'b11);
    do_issue(3'd5, 12'h00C, 2'b11, 12'h000, 2'b10);
    vectors++;
    if ({issue_ready, issue_tag, disp_valid} !== {1'b0, 2'b11, 1'b0}) begin
      miscompares++;
      $display("FAIL full_flags: ready/tag/dv got %b want 0_11_0", {issue_ready, issue_tag, disp_valid});
    end
    do_issue(3'd6, 12'h001, 2'b11, 12'h002, 2'b11);
    vectors++;
    if ({issue_ready, disp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL full_ignore: ready/dv got %b want 00", {issue_ready, disp_valid});
    end
    cdb_valid = 1'b1; cdb_tag = 2'b10; cdb_data = 12'hABC;
    @(negedge clk);
    cdb_valid = 1'b0;
    vectors++;
    if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 3'd4, 12'hABC, 12'h00B, 2'd0}) begin
      miscompares++;
      $display("FAIL full_wake: got %h want %h", {disp_valid, disp_op, disp_a, disp_b, disp_tag},
               {1'b1, 3'd4, 12'hABC, 12'h00B, 2'd0});
    end
    @(negedge clk);
    vectors++;
    if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 3'd4, 12'hABC, 12'h00B, 2'd0}) begin
      miscompares++;
      $display("FAIL full_hold: got %h want %h", {disp_valid, disp_op, disp_a, disp_b, disp_tag},
               {1'b1, 3'd4, 12'hABC, 12'h00B, 2'd0});
    end
    // Pop entry 0 while issuing: the freed slot must not be reused this edge.
    issue_op = 3'd7; issue_vj = 12'h777; issue_qj = 2'b11; issue_vk = 12'h888; issue_qk = 2'b11;
    issue_valid = 1'b1; disp_ready = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0; disp_ready = 1'b0;
    vectors++;
    if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 3'd5, 12'h00C, 12'hABC, 2'd1}) begin
      miscompares++;
      $display("FAIL full_second: got %h want %h", {disp_valid, disp_op, disp_a, disp_b, disp_tag},
               {1'b1, 3'd5, 12'h00C, 12'hABC, 2'd1});
    end
    vectors++;
    if ({issue_ready, issue_tag} !== {1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL full_no_realloc: ready/tag got %b want 1_00", {issue_ready, issue_tag});
    end
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
    vectors++;
    if ({disp_valid, issue_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL full_drain: dv/ready got %b want 01", {disp_valid, issue_ready});
    end
  endtask

  task automatic test_priority;
    do_issue(3'd1, 12'h00A, 2'b11, 12'h00B, 2'b11);
    do_issue(3'd2, 12'h000, 2'b10, 12'h00D, 2'b11);
    vectors++;
    if ({disp_valid, disp_op, disp_tag} !== {1'b1, 3'd1, 2'd0}) begin
      miscompares++;
      $display("FAIL prio_first: dv/op/tag got %b want 1_001_00", {disp_valid, disp_op, disp_tag});
    end
    // CDB with the "valid" label must be ignored while entry 0 dispatches.
    cdb_valid = 1'b1; cdb_tag = 2'b11; cdb_data = 12'hFFF; disp_ready = 1'b1;
    @(negedge clk);
    cdb_valid = 1'b0; disp_ready = 1'b0;
    vectors++;
    if ({disp_valid, issue_ready, issue_tag} !== {1'b0, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL prio_tag11: dv/ready/tag got %b want 0_1_00", {disp_valid, issue_ready, issue_tag});
    end
    // Issue into entry 0 and wake entry 1 on the same edge.
    cdb_valid = 1'b1; cdb_tag = 2'b10; cdb_data = 12'h321;
    do_issue(3'd3, 12'h030, 2'b11, 12'h040, 2'b11);
    cdb_valid = 1'b0;
    vectors++;
    if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 3'd3, 12'h030, 12'h040, 2'd0}) begin
      miscompares++;
      $display("FAIL prio_entry0: got %h want %h", {disp_valid, disp_op, disp_a, disp_b, disp_tag},
               {1'b1, 3'd3, 12'h030, 12'h040, 2'd0});
    end
    disp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 3'd2, 12'h321, 12'h00D, 2'd1}) begin
      miscompares++;
      $display("FAIL prio_entry1: got %h want %h", {disp_valid, disp_op, disp_a, disp_b, disp_tag},
               {1'b1, 3'd2, 12'h321, 12'h00D, 2'd1});
    end
    @(negedge clk);
    disp_ready = 1'b0;
    vectors++;
    if ({disp_valid, issue_ready, issue_tag} !== {1'b0, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL prio_empty: dv/ready/tag got %b want 0_1_00", {disp_valid, issue_ready, issue_tag});
    end
  endtask

  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_bypass();
    test_full();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
